// File: rtl/march_patgen.sv
// March C- pattern generator for the SRAM BIST patgen port.
// Optional checkerboard second pass: define MARCH_PATGEN_CHECKERBOARD_EN.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance one operation per cycle while high
//   addr       : current address
//   data       : write data
//   check      : expected read data
//   wmask      : write mask, always all ones
//   we, re     : write / read strobes
//   done       : sequence complete
//   elem       : current March element 0..5
//   bg         : data background (0 solid, 1 checkerboard)
module march_patgen #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4,
    parameter int MAX_ADDR   = 2**ADDR_WIDTH-1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] check,
    output logic [MASK_WIDTH-1:0] wmask,
    output logic                  we,
    output logic                  re,
    output logic                  done,
    output logic [2:0]            elem,
    output logic                  bg
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MAX_ADDR);

    typedef enum logic {
        S_RUN,
        S_DONE
    } state_t;

    state_t                state_q, state_n;
    logic [2:0]            elem_q, elem_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic                  op_q, op_n;
    logic                  bg_q;

`ifdef MARCH_PATGEN_CHECKERBOARD_EN
    logic bg_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bg_q <= 1'b0;
        end else begin
            bg_q <= bg_n;
        end
    end
`else
    assign bg_q = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            elem_q  <= 3'd0;
            addr_q  <= '0;
            op_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            elem_q  <= elem_n;
            addr_q  <= addr_n;
            op_q    <= op_n;
        end
    end

    logic                  single;
    logic                  down;
    logic                  last_op;
    logic [ADDR_WIDTH-1:0] end_addr;

    // M0 and M5 have one operation per address, M3/M4 walk downwards.
    always_comb begin
        single   = (elem_q == 3'd0) || (elem_q == 3'd5);
        down     = (elem_q == 3'd3) || (elem_q == 3'd4);
        last_op  = single || op_q;
        end_addr = down ? '0 : LAST;
    end

    always_comb begin
        state_n = state_q;
        elem_n  = elem_q;
        addr_n  = addr_q;
        op_n    = op_q;
`ifdef MARCH_PATGEN_CHECKERBOARD_EN
        bg_n    = bg_q;
`endif
        if (state_q == S_RUN && en) begin
            if (!last_op) begin
                op_n = 1'b1;
            end else if (addr_q != end_addr) begin
                op_n   = 1'b0;
                addr_n = down ? addr_q - 1'b1 : addr_q + 1'b1;
            end else if (elem_q != 3'd5) begin
                op_n   = 1'b0;
                elem_n = elem_q + 3'd1;
                // Next element is M3 or M4: start at the top.
                addr_n = (elem_q == 3'd2 || elem_q == 3'd3) ? LAST : '0;
            end else begin
`ifdef MARCH_PATGEN_CHECKERBOARD_EN
                if (!bg_q) begin
                    bg_n   = 1'b1;
                    elem_n = 3'd0;
                    addr_n = '0;
                    op_n   = 1'b0;
                end else begin
                    state_n = S_DONE;
                end
`else
                state_n = S_DONE;
`endif
            end
        end
    end

    logic                  wr;
    logic                  val;
    logic [DATA_WIDTH-1:0] bpat;
    logic                  run;

    always_comb begin
        run = (state_q == S_RUN);
        wr  = (elem_q == 3'd0) || op_q;
        val = 1'b0;
        unique case (1'b1)
            (elem_q == 3'd1) || (elem_q == 3'd3): val = op_q;
            (elem_q == 3'd2) || (elem_q == 3'd4): val = ~op_q;
            default:                              val = 1'b0;
        endcase
        // Checkerboard: bit parity XOR address parity.
        for (int i = 0; i < DATA_WIDTH; i++) begin
            bpat[i] = bg_q & (addr_q[0] ^ i[0]);
        end
    end

    always_comb begin
        wmask = '1;
        done  = ~run;
        we    = run & wr;
        re    = run & ~wr;
        addr  = run ? addr_q : '0;
        data  = '0;
        if (run) begin
            data = val ? ~bpat : bpat;
        end
        check = data;
        elem  = elem_q;
        bg    = bg_q;
    end

endmodule

// File: tb/tb_march_patgen.sv
// Self-checking bench for march_patgen.
// Two instances: 4-deep (AW=2) and 5-deep (AW=3, MAX_ADDR=4).
module tb_march_patgen;

`ifdef MARCH_PATGEN_CHECKERBOARD_EN
    localparam bit CB = 1'b1;
`else
    localparam bit CB = 1'b0;
`endif

    localparam int NA = 4;
    localparam int NB = 5;

    logic clk;
    logic rst_n;
    logic en;

    logic [1:0] a_addr;
    logic [7:0] a_data, a_check;
    logic [3:0] a_wmask;
    logic       a_we, a_re, a_done, a_bg;
    logic [2:0] a_elem;

    logic [2:0] b_addr;
    logic [7:0] b_data, b_check;
    logic [3:0] b_wmask;
    logic       b_we, b_re, b_done, b_bg;
    logic [2:0] b_elem;

    march_patgen #(
        .ADDR_WIDTH(2), .DATA_WIDTH(8),
        .MASK_WIDTH(4), .MAX_ADDR(3)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en),
        .addr(a_addr), .data(a_data), .check(a_check),
        .wmask(a_wmask), .we(a_we), .re(a_re),
        .done(a_done), .elem(a_elem), .bg(a_bg)
    );

    march_patgen #(
        .ADDR_WIDTH(3), .DATA_WIDTH(8),
        .MASK_WIDTH(4), .MAX_ADDR(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en),
        .addr(b_addr), .data(b_data), .check(b_check),
        .wmask(b_wmask), .we(b_we), .re(b_re),
        .done(b_done), .elem(b_elem), .bg(b_bg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int addr;
        bit wr;
        bit val;
        int elem;
        bit bg;
    } op_t;

    op_t qa[$];
    op_t qb[$];
    int  ia, ib;
    bit  built;
    int  errors;
    int  checks;
    int  b_max;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    // Expected sequence written straight from the element list.
    task automatic build(input int n, input bit to_b);
        string ops[6];
        op_t   o;
        int    a;
        ops = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};
        for (int p = 0; p < (CB ? 2 : 1); p++) begin
            for (int e = 0; e < 6; e++) begin
                for (int s = 0; s < n; s++) begin
                    a = (e == 3 || e == 4) ? n - 1 - s : s;
                    for (int k = 0; k < ops[e].len(); k += 2) begin
                        o.addr = a;
                        o.wr   = (ops[e].getc(k) == "w");
                        o.val  = (ops[e].getc(k + 1) == "1");
                        o.elem = e;
                        o.bg   = (p == 1);
                        if (to_b) qb.push_back(o);
                        else qa.push_back(o);
                    end
                end
            end
        end
    endtask

    function automatic logic [7:0] pat(input int a, input bit b,
                                       input bit v);
        logic [7:0] x;
        for (int i = 0; i < 8; i++) begin
            x[i] = b & ((i % 2) != (a % 2));
        end
        return v ? ~x : x;
    endfunction

    // Sequence position: one operation per enabled edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ia <= 0;
            ib <= 0;
        end else if (en) begin
            if (ia < qa.size()) ia <= ia + 1;
            if (ib < qb.size()) ib <= ib + 1;
        end
    end

    task automatic cmp_one(input string nm, input op_t q[$], input int idx,
                           input int addr, input int data, input int chkv,
                           input int wm, input bit w, input bit r,
                           input bit d, input int el, input bit b);
        logic [7:0] v;
        if (idx < q.size()) begin
            v = pat(q[idx].addr, q[idx].bg, q[idx].val);
            chk({nm, ".addr"}, addr, q[idx].addr);
            chk({nm, ".we"}, int'(w), int'(q[idx].wr));
            chk({nm, ".re"}, int'(r), int'(!q[idx].wr));
            chk({nm, ".data"}, data, int'(v));
            chk({nm, ".check"}, chkv, int'(v));
            chk({nm, ".done"}, int'(d), 0);
            chk({nm, ".elem"}, el, q[idx].elem);
            chk({nm, ".bg"}, int'(b), int'(q[idx].bg));
        end else begin
            chk({nm, ".done"}, int'(d), 1);
            chk({nm, ".we"}, int'(w), 0);
            chk({nm, ".re"}, int'(r), 0);
            chk({nm, ".addr"}, addr, 0);
            chk({nm, ".data"}, data, 0);
            chk({nm, ".check"}, chkv, 0);
        end
        chk({nm, ".wmask"}, wm, 4'hF);
    endtask

    always @(negedge clk) begin
        if (built) begin
            cmp_one("a", qa, ia, int'(a_addr), int'(a_data),
                    int'(a_check), int'(a_wmask), a_we, a_re,
                    a_done, int'(a_elem), a_bg);
            cmp_one("b", qb, ib, int'(b_addr), int'(b_data),
                    int'(b_check), int'(b_wmask), b_we, b_re,
                    b_done, int'(b_elem), b_bg);
            if (int'(b_addr) > b_max) b_max = int'(b_addr);
        end
    end

    int  n, cyc, da, db;
    bit  e;

    initial begin
        errors = 0;
        checks = 0;
        b_max  = 0;
        built  = 1'b0;
        rst_n  = 1'b0;
        en     = 1'b0;
        build(NA, 1'b0);
        build(NB, 1'b1);

        // Model pinned against hand-derived values.
        chk("model.lenA", qa.size(), CB ? 80 : 40);
        chk("model.lenB", qb.size(), CB ? 100 : 50);
        chk("model.a4.re", int'(qa[4].wr), 0);
        chk("model.a5.val", int'(qa[5].val), 1);
        chk("model.a20.elem", qa[20].elem, 3);
        chk("model.a20.addr", qa[20].addr, 3);
        chk("model.a36.elem", qa[36].elem, 5);
        chk("model.b25.addr", qb[25].addr, 4);
        chk("model.pat.aa", int'(pat(0, 1'b1, 1'b0)), 8'hAA);
        chk("model.pat.55", int'(pat(1, 1'b1, 1'b0)), 8'h55);
        built = 1'b1;

        // Reset state.
        #3;
        chk("rst.elem", int'(a_elem), 0);
        chk("rst.addr", int'(a_addr), 0);
        chk("rst.we", int'(a_we), 1);
        chk("rst.re", int'(a_re), 0);
        chk("rst.data", int'(a_data), 0);
        chk("rst.wmask", int'(a_wmask), 4'hF);
        chk("rst.done", int'(a_done), 0);
        chk("rst.bg", int'(a_bg), 0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Full run with a 3-cycle stall at cycle 6.
        n = 0; cyc = 0; da = -1; db = -1;
        while ((da < 0 || db < 0) && cyc < 400) begin
            if (n == 4) begin
                chk("c4.addr", int'(a_addr), 0);
                chk("c4.re", int'(a_re), 1);
                chk("c4.check", int'(a_check), 0);
            end
            if (n == 5) begin
                chk("c5.we", int'(a_we), 1);
                chk("c5.data", int'(a_data), 8'hFF);
            end
            if (n == 6) begin
                chk("stall.addr", int'(a_addr), 1);
                chk("stall.re", int'(a_re), 1);
            end
            if (n == 20) begin
                chk("c20.elem", int'(a_elem), 3);
                chk("c20.addr", int'(a_addr), 3);
                chk("c20.re", int'(a_re), 1);
                chk("c20.check", int'(a_check), 0);
            end
            if (n == 25) begin
                chk("b.m3start.elem", int'(b_elem), 3);
                chk("b.m3start.addr", int'(b_addr), 4);
            end
            if (n == 36) begin
                chk("c36.elem", int'(a_elem), 5);
                chk("c36.addr", int'(a_addr), 0);
            end
            if (CB && n == 40) begin
                chk("c40.bg", int'(a_bg), 1);
                chk("c40.elem", int'(a_elem), 0);
                chk("c40.addr", int'(a_addr), 0);
                chk("c40.data", int'(a_data), 8'hAA);
            end
            if (CB && n == 41) begin
                chk("c41.addr", int'(a_addr), 1);
                chk("c41.data", int'(a_data), 8'h55);
            end
            e = !(cyc >= 6 && cyc < 9);
            en = e;
            @(posedge clk); #2;
            cyc++;
            if (e) n++;
            if (a_done && da < 0) da = cyc;
            if (b_done && db < 0) db = cyc;
        end
        chk("a.done_cycle", da, (CB ? 80 : 40) + 3);
        chk("b.done_cycle", db, (CB ? 100 : 50) + 3);
        chk("b.max_addr", b_max, 4);

        // DONE ignores en.
        for (int k = 0; k < 10; k++) begin
            en = k[0];
            @(posedge clk); #2;
            chk("hold.a.done", int'(a_done), 1);
            chk("hold.b.done", int'(b_done), 1);
            chk("hold.a.we", int'(a_we), 0);
            chk("hold.a.re", int'(a_re), 0);
        end

        // Async reset mid-element.
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        en = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #2;
        end
        chk("pre.elem", int'(a_elem), 3);
        rst_n = 1'b0;
        #1;
        chk("arst.elem", int'(a_elem), 0);
        chk("arst.addr", int'(a_addr), 0);
        chk("arst.we", int'(a_we), 1);
        chk("arst.done", int'(a_done), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Rerun from M0 to completion.
        cyc = 0;
        while (!a_done && cyc < 200) begin
            @(posedge clk); #2;
            cyc++;
        end
        chk("rerun.a.done_cycle", cyc, CB ? 80 : 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
